// File: rtl/montador_serial_nibble.sv
`default_nettype none
// ============================================================================
// Module   : montador_serial_nibble
// Purpose  : Serial-to-parallel front end for a 4-bit parallel-load register.
//            Receives frames of 4 data bits (MSB first) followed by one odd
//            parity bit. A good frame is presented on d with a one-cycle ld
//            strobe. An abort becomes a one-cycle clr strobe. Parity failures
//            and inter-bit timeouts are flagged with one-cycle pulses.
// Ports    : clk      - clock, rising edge
//            rst      - synchronous active-high reset
//            s_in     - serial data bit
//            s_valid  - s_in is sampled when high
//            abort    - drop the partial frame and request a register clear
//            d        - assembled nibble, held until the next good frame
//            ld       - one-cycle load strobe (d valid in the same cycle)
//            clr      - one-cycle clear strobe
//            err_par  - one-cycle parity error pulse
//            err_to   - one-cycle timeout pulse
//            busy     - a frame is partially received
// Revision : 1.0 - initial release
// ============================================================================
module montador_serial_nibble #(
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_in,
    input  logic       s_valid,
    input  logic       abort,
    output logic [3:0] d,
    output logic       ld,
    output logic       clr,
    output logic       err_par,
    output logic       err_to,
    output logic       busy
);

    localparam logic       S_IDLE  = 1'b0;
    localparam logic       S_SHIFT = 1'b1;
    // The counter value that, plus one more idle edge, reaches TIMEOUT.
    localparam logic [7:0] c_IDLE_LAST = 8'(TIMEOUT - 1);

    logic       state_q,   state_d;
    logic [2:0] cnt_q,     cnt_d;
    logic [7:0] idle_q,    idle_d;
    logic [3:0] sh_q,      sh_d;
    logic [3:0] d_q,       d_d;
    logic       ld_q,      ld_d;
    logic       clr_q,     clr_d;
    logic       err_par_q, err_par_d;
    logic       err_to_q,  err_to_d;
    logic       busy_q,    busy_d;

    logic       w_good;
    logic       w_bad;
    logic       w_abort;
    logic       w_timeout;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            idle_q    <= 8'd0;
            sh_q      <= 4'd0;
            d_q       <= 4'd0;
            ld_q      <= 1'b0;
            clr_q     <= 1'b0;
            err_par_q <= 1'b0;
            err_to_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            sh_q      <= sh_d;
            d_q       <= d_d;
            ld_q      <= ld_d;
            clr_q     <= clr_d;
            err_par_q <= err_par_d;
            err_to_q  <= err_to_d;
            busy_q    <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        sh_d      = sh_q;
        d_d       = d_q;
        w_good    = 1'b0;
        w_bad     = 1'b0;
        w_abort   = 1'b0;
        w_timeout = 1'b0;

        if (abort) begin
            // Abort wins over a simultaneous bit, even the parity bit.
            cnt_d   = 3'd0;
            idle_d  = 8'd0;
            w_abort = 1'b1;
        end else if (s_valid) begin
            idle_d = 8'd0;
            if (cnt_q == 3'd4) begin
                // Parity bit: odd parity over the 4 data bits plus this bit.
                cnt_d = 3'd0;
                if ((^sh_q) ^ s_in) begin
                    d_d    = sh_q;
                    w_good = 1'b1;
                end else begin
                    w_bad  = 1'b1;
                end
            end else begin
                sh_d  = {sh_q[2:0], s_in};
                cnt_d = cnt_q + 3'd1;
            end
        end else if (state_q == S_SHIFT) begin
            if (idle_q == c_IDLE_LAST) begin
                cnt_d     = 3'd0;
                idle_d    = 8'd0;
                w_timeout = 1'b1;
            end else begin
                idle_d = idle_q + 8'd1;
            end
        end

        state_d = (cnt_d != 3'd0) ? S_SHIFT : S_IDLE;
    end

    // ------------------------------------------------------------------
    // Output logic (registered on the next edge)
    // ------------------------------------------------------------------
    always_comb begin
        ld_d      = w_good;
        clr_d     = w_abort;
        err_par_d = w_bad;
        err_to_d  = w_timeout;
        busy_d    = (state_d == S_SHIFT);
    end

    assign d       = d_q;
    assign ld      = ld_q;
    assign clr     = clr_q;
    assign err_par = err_par_q;
    assign err_to  = err_to_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: doc/montador_serial_nibble.md
# montador_serial_nibble

- Serial-to-parallel front end for the 4-bit parallel-load register.
- Collects a serial frame of 4 data bits (MSB first) plus 1 odd-parity bit.
- On a good frame, presents the nibble on `d` and pulses `ld` for one cycle, driving the register's `d`/`ld` directly.
- Converts an external abort into a one-cycle `clr` pulse for the register, and flags parity and inter-bit timeout errors.

## Interface
- `TIMEOUT`, default 8: consecutive idle cycles tolerated mid-frame before the frame is dropped (legal range 1–255).
- Reset is synchronous and active-high. One clock domain.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `s_in`  in  1  serial data bit.
- `s_valid`  in  1  `s_in` is sampled on the rising edge when this is 1.
- `abort`  in  1  discard any partial frame and request a register clear.
- `d`  out  4  assembled nibble, held until the next good frame.
- `ld`  out  1  one-cycle load strobe; `d` is valid in the same cycle.
- `clr`  out  1  one-cycle clear strobe for the downstream register.
- `err_par`  out  1  one-cycle pulse: parity failure, frame discarded.
- `err_to`  out  1  one-cycle pulse: timeout, frame discarded.
- `busy`  out  1  1 while a frame is partially received (bit count > 0).

## Operation
- **States:**
  - IDLE: bit count 0.
  - SHIFT: 1–4 bits accepted.
- **Bit acceptance:** a bit is accepted on any edge with `s_valid`=1 and `abort`=0.
  - Data bits shift into an internal shift register, MSB first.
  - The 5th accepted bit is the parity bit.
- **Frame end:** on the edge accepting the parity bit, return to IDLE and evaluate odd parity (data bits XOR parity bit = 1).
  - Good frame: `d` <= shift register; `ld`=1 next cycle.
  - Bad frame: `d` unchanged; `err_par`=1 next cycle; `ld` stays 0.
- **Back-to-back frames:** no gap is required. A bit presented in the cycle where `ld`/`err_par` is high is the first data bit of the next frame.
- **Timeout:** in SHIFT, an idle counter counts consecutive edges with `s_valid`=0.
  - It clears on every accepted bit.
  - When it reaches `TIMEOUT`: go to IDLE, discard the bits, and pulse `err_to` the next cycle.
  - The counter is inactive in IDLE.
- **Abort:** in any state, go to IDLE, clear the bit count and idle counter, and pulse `clr` the next cycle. `d` is unchanged.
  - `abort` has priority over `s_valid` in the same cycle, including on the parity bit: that frame produces no `ld` or `err_par`.
- **Pulse exclusivity:** at most one of `ld`, `err_par`, `err_to`, `clr` is high in any cycle.
- **Held abort:** if `abort` is held high, `clr` is high every cycle after the first.
- **Reset:** `rst` forces IDLE; all counters cleared; `d`=0; `ld`=`clr`=`err_par`=`err_to`=`busy`=0. Any frame in flight is dropped with no pulse.

## Timing
- All outputs are registered.
- Latency: parity bit accepted at edge N → `ld`/`err_par` high for the cycle after edge N only.
- `d` updates at edge N and is stable for at least the whole `ld` cycle and beyond.
- `busy` goes 1 the cycle after the first accepted bit and 0 the cycle after frame end, timeout, or abort.
- Timeout: the last accepted bit is at edge M; with no further valid bits, the idle counter reaches `TIMEOUT` at edge M+`TIMEOUT`, and `err_to` is high in the following cycle.
- A valid bit at edge M+`TIMEOUT` (`TIMEOUT`=8: edge M+8) is accepted and prevents the timeout.
- Abort at edge A → `clr` high in the following cycle.
- Throughput: one nibble per 5 valid cycles; 5 consecutive `s_valid` cycles give 1 `ld` every 5 cycles.

## Test plan
- Reset, then frame bits 1,0,1,1 with parity 0 on 5 consecutive cycles → `d`=4'b1011, `ld` high exactly 1 cycle after the 5th bit, `busy` high for 4 cycles.
- Frame 1,0,1,1 with parity 1 → `err_par` pulse, no `ld`, `d` keeps its previous value (4'b1011).
- Two frames back-to-back, 0,0,0,0/1 then 1,1,1,1/1 → `ld` twice, 5 cycles apart, `d`=4'b0000 then 4'b1111.
- With `TIMEOUT`=8: bits 1,1, then 8 idle cycles → `err_to` pulse, `busy`→0. Repeat with 7 idle cycles, then the remaining 3 bits with parity 1 for data 1,1,0,0 → `ld`, `d`=4'b1100, no `err_to`.
- `abort` together with the parity bit of a good frame → `clr` pulse, no `ld`, `d` unchanged, next frame received normally.
- `rst` asserted after 3 accepted bits → all outputs 0 next cycle. A following full frame 0,1,0,1 with parity 1 → `d`=4'b0101, `ld`.
